// File: rtl/branch_predictor_bht.sv
// Fetch-stage branch predictor: PC-indexed saturating-counter table plus an
// in-order FIFO of unresolved predictions, with redirect/flush on mispredict.
module branch_predictor_bht #(
    parameter int DATA_WIDTH   = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int COUNTER_BITS = 2,
    parameter int QUEUE_DEPTH  = 4,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  StallF,
    input  logic                  BranchE,
    input  logic                  TakenE,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  flushBranch,
    output logic                  stallBPU,
    output logic [PERF_WIDTH-1:0] branchCount,
    output logic [PERF_WIDTH-1:0] mispredictCount
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W:0]          DEPTH    = (PTR_W + 1)'(QUEUE_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] branchAddr;
        logic [DATA_WIDTH-1:0] targetAddr;
        logic [IDX_W-1:0]      index;
        logic                  prediction;
    } qentry_t;

    logic [COUNTER_BITS-1:0] bht_q [BHT_ENTRIES];
    qentry_t                 queue_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]        front_q, back_q;
    logic [PTR_W:0]          count_q, count_d;
    logic [PERF_WIDTH-1:0]   branch_cnt_q, mispred_cnt_q;

    logic                  isBranchF, predTaken, resolve, mispredict, pop_ok;
    logic                  full, blocked, enq;
    logic [IDX_W-1:0]      fetch_idx;
    logic signed [31:0]    imm_b;
    logic [DATA_WIDTH-1:0] target;
    qentry_t               head;

    assign isBranchF = (RD[6:0] == 7'b1100011);
    assign imm_b     = {{20{RD[31]}}, RD[7], RD[30:25], RD[11:8], 1'b0};
    assign target    = PCF + DATA_WIDTH'(imm_b);
    assign fetch_idx = PCF[IDX_W+1:2];
    assign predTaken = bht_q[fetch_idx][COUNTER_BITS-1];

    assign head       = queue_q[front_q];
    assign resolve    = BranchE && (count_q != '0);
    assign mispredict = resolve && (head.prediction != TakenE);
    assign pop_ok     = resolve && !mispredict;

    // A correct resolve frees the head slot this cycle, so a full queue can still accept.
    assign full      = (count_q == DEPTH);
    assign blocked   = full && !pop_ok;
    assign enq       = isBranchF && !StallF && !blocked && !mispredict;
    assign stallBPU  = isBranchF && blocked;

    always_comb begin
        PCBPUSrc    = 1'b0;
        PCBPU       = '0;
        flushBranch = 1'b0;
        if (mispredict) begin
            PCBPUSrc    = 1'b1;
            flushBranch = 1'b1;
            PCBPU       = TakenE ? head.targetAddr : head.branchAddr + DATA_WIDTH'(4);
        end else if (isBranchF) begin
            PCBPUSrc = predTaken && !blocked && !StallF;
            PCBPU    = target;
        end
    end

    always_comb begin
        count_d = count_q;
        if (mispredict)
            count_d = '0;
        else if (enq && !pop_ok)
            count_d = count_q + 1'b1;
        else if (!enq && pop_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q <= '0;
            back_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (mispredict) begin
                front_q <= '0;
                back_q  <= '0;
            end else begin
                if (pop_ok) front_q <= front_q + 1'b1;
                if (enq) begin
                    queue_q[back_q] <= '{branchAddr: PCF, targetAddr: target,
                                         index: fetch_idx, prediction: predTaken};
                    back_q <= back_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
        end else if (resolve) begin
            if (TakenE && bht_q[head.index] != CNT_MAX)
                bht_q[head.index] <= bht_q[head.index] + 1'b1;
            else if (!TakenE && bht_q[head.index] != '0)
                bht_q[head.index] <= bht_q[head.index] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (resolve) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end

    assign branchCount     = branch_cnt_q;
    assign mispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized bench for branch_predictor_bht against a queue/array reference model.
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD, PCF;
    logic        StallF, BranchE, TakenE;
    logic [31:0] PCBPU;
    logic        PCBPUSrc, flushBranch, stallBPU;
    logic [31:0] branchCount, mispredictCount;

    branch_predictor_bht dut (
        .clk(clk), .rst(rst), .RD(RD), .PCF(PCF), .StallF(StallF),
        .BranchE(BranchE), .TakenE(TakenE), .PCBPU(PCBPU), .PCBPUSrc(PCBPUSrc),
        .flushBranch(flushBranch), .stallBPU(stallBPU),
        .branchCount(branchCount), .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ba;
        logic [31:0] ta;
        int          idx;
        bit          pred;
    } ent_t;

    ent_t q[$];
    int   ctr[64];
    int   m_bc, m_mc;
    int   n_tests = 0, n_fail = 0;

    logic        o_src, o_flush, o_stall;
    logic [31:0] o_pc, o_bc, o_mc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 64; i++) ctr[i] = 2;
        m_bc = 0;
        m_mc = 0;
    endtask

    function automatic logic [31:0] beq(input int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic step(input logic [31:0] rd, input logic [31:0] pc,
                        input logic st, input logic be, input logic te, input logic r);
        bit          isb, pred, res, mis, pop, blk, enq, e_src, e_flush, e_stall;
        int          imm, idx;
        logic [31:0] tgt, e_pc;
        @(negedge clk);
        RD = rd; PCF = pc; StallF = st; BranchE = be; TakenE = te; rst = r;
        #1;
        isb = (rd[6:0] == 7'h63);
        imm = (rd[31] ? -4096 : 0) + int'(rd[7]) * 2048 + int'(rd[30:25]) * 32 + int'(rd[11:8]) * 2;
        tgt = pc + 32'(imm);
        idx = int'((pc >> 2) % 64);
        pred = (ctr[idx] >= 2);
        res = be && (q.size() > 0);
        mis = res && (q[0].pred != te);
        pop = res && !mis;
        blk = (q.size() == 4) && !pop;
        enq = isb && !st && !blk && !mis;
        e_stall = isb && blk;
        e_flush = mis;
        if (mis) begin
            e_src = 1;
            e_pc  = te ? q[0].ta : q[0].ba + 32'd4;
        end else if (isb) begin
            e_src = pred && !blk && !st;
            e_pc  = tgt;
        end else begin
            e_src = 0;
            e_pc  = 0;
        end
        o_src = PCBPUSrc; o_pc = PCBPU; o_flush = flushBranch; o_stall = stallBPU;
        o_bc = branchCount; o_mc = mispredictCount;
        check("pcbpusrc", o_src, e_src);
        check("pcbpu", o_pc, e_pc);
        check("flush", o_flush, e_flush);
        check("stall", o_stall, e_stall);
        check("branchcnt", o_bc, m_bc);
        check("mispredcnt", o_mc, m_mc);
        if (r) begin
            model_reset();
        end else begin
            if (res) begin
                if (te) ctr[q[0].idx] = (ctr[q[0].idx] < 3) ? ctr[q[0].idx] + 1 : 3;
                else    ctr[q[0].idx] = (ctr[q[0].idx] > 0) ? ctr[q[0].idx] - 1 : 0;
                m_bc++;
                if (mis) m_mc++;
                if (mis) q.delete();
                else void'(q.pop_front());
            end
            if (enq) q.push_back('{ba: pc, ta: tgt, idx: idx, pred: pred});
        end
        @(posedge clk);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        logic [31:0] rd, pc;
        rst = 1'b1; RD = NOP; PCF = 0; StallF = 0; BranchE = 0; TakenE = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // reset state
        step(NOP, 32'h100, 0, 0, 0, 0);
        check("rst_src", o_src, 0);
        check("rst_pc", o_pc, 0);
        check("rst_bc", o_bc, 0);

        // weakly-taken prediction, then not-taken mispredict
        step(beq(16), 32'h100, 0, 0, 0, 0);
        check("t1_src", o_src, 1);
        check("t1_pc", o_pc, 32'h110);
        step(NOP, 32'h110, 0, 1, 0, 0);
        check("t2_flush", o_flush, 1);
        check("t2_pc", o_pc, 32'h104);
        step(beq(16), 32'h100, 0, 0, 0, 0);
        check("t2_refetch", o_src, 0);
        check("t2_mc", o_mc, 1);

        // saturation at one PC, no wrap
        step(NOP, 32'h104, 0, 1, 0, 0);                 // resolve the refetched branch not-taken
        for (int i = 0; i < 5; i++) begin
            step(beq(-8), 32'h100, 0, 0, 0, 0);
            step(NOP, 32'h104, 0, 1, (i < 4), 0);
        end
        step(beq(-8), 32'h100, 0, 0, 0, 0);
        check("t3_still_taken", o_src, 1);
        check("t3_target", o_pc, 32'hF8);
        step(NOP, 32'h104, 0, 1, 1, 0);

        // fill queue, stall, then simultaneous pop/push
        for (int i = 0; i < 4; i++) step(beq(32), 32'h200 + 4 * i, 0, 0, 0, 0);
        step(beq(32), 32'h210, 0, 0, 0, 0);
        check("t4_stall", o_stall, 1);
        check("t4_nosrc", o_src, 0);
        step(beq(32), 32'h210, 0, 1, 1, 0);
        check("t4_popush_stall", o_stall, 0);
        check("t4_popush_flush", o_flush, 0);
        step(beq(32), 32'h214, 0, 0, 0, 0);
        check("t4_still_full", o_stall, 1);
        for (int i = 0; i < 4; i++) step(NOP, 32'h300, 0, 1, 1, 0);

        // empty-queue resolve ignored
        step(NOP, 32'h300, 0, 1, 0, 0);
        check("t5_noredirect", o_src, 0);
        step(NOP, 32'h300, 0, 0, 0, 0);
        check("t5_bc_unchanged", o_bc, m_bc);

        // mid-stream reset with pending resolve
        for (int i = 0; i < 3; i++) step(beq(64), 32'h400 + 4 * i, 0, 0, 0, 0);
        step(NOP, 32'h500, 0, 1, 0, 1);
        step(NOP, 32'h500, 0, 0, 0, 0);
        check("t6_bc", o_bc, 0);
        check("t6_mc", o_mc, 0);
        check("t6_flush", o_flush, 0);
        step(beq(16), 32'h100, 0, 0, 0, 0);
        check("t6_weak_taken", o_src, 1);
        step(NOP, 32'h104, 0, 1, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rd = $urandom;
            if ($urandom_range(0, 1)) rd[6:0] = 7'h63;
            else                      rd[6:0] = 7'h13;
            if ($urandom_range(0, 1)) pc = 32'h100 + 4 * $urandom_range(0, 7);
            else                      pc = $urandom & 32'hFFFF_FFFC;
            step(rd, pc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
                 $urandom_range(0, 1), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
